// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit:
// FSM states, opcodes and the datapath mux/ALU select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that stall on the memory ready handshake.
  function automatic logic is_mem_wait(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_wait_timer.sv
// Memory-wait watchdog: counts enabled cycles, flags the cycle that is the
// MEM_WAIT_MAX-th consecutive wait. MEM_WAIT_MAX must lie in 1..255.
module mips_wait_timer #(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(MEM_WAIT_MAX - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  assign expired = en && (cnt_q == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS main control: sequences FETCH/DECODE/execute states,
// memory accesses wait on mem_ready with a timeout watchdog.
module mips_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ula_operation,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op,
  output logic             mem_error
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             illegal_q, mem_err_q;
  logic             pcw, pcwc, mrd, mwr, irw, rw;
  logic             retire, illegal_set, wait_en, wait_clr, timeout;

  assign wait_en  = is_mem_wait(state_q) && !mem_ready;
  assign wait_clr = !wait_en || (state_d != state_q) || timeout;

  mips_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (timeout)
  );

  always_comb begin
    state_d       = state_q;
    pcw           = 1'b0;
    pcwc          = 1'b0;
    mrd           = 1'b0;
    mwr           = 1'b0;
    irw           = 1'b0;
    rw            = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PCSRC_ALU;
    i_or_d        = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    ula_operation = ULA_ADD;
    retire        = 1'b0;
    illegal_set   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mrd       = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEXEC;
          OP_J:          state_d = S_JUMP;
          default: begin
            state_d     = S_FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mrd    = 1'b1;
        i_or_d = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        rw         = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mwr    = 1'b1;
        i_or_d = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a     = 1'b1;
        ula_operation = ULA_FUNCT;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        rw      = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        ula_operation = ULA_SUB;
        pcwc          = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        rw      = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcw       = 1'b1;
        pc_source = PCSRC_JUMP;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Abandoned access: no retire is possible here since timeout implies !mem_ready.
    if (timeout) state_d = S_FETCH;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      count_q   <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)      count_q   <= count_q + CNT_W'(1);
      if (illegal_set) illegal_q <= 1'b1;
      if (timeout)     mem_err_q <= 1'b1;
    end
  end

  assign pc_write      = pcw  & ~reset;
  assign pc_write_cond = pcwc & ~reset;
  assign mem_read      = mrd  & ~reset;
  assign mem_write     = mwr  & ~reset;
  assign ir_write      = irw  & ~reset;
  assign reg_write     = rw   & ~reset;
  assign state_dbg     = state_q;
  assign instr_count   = count_q;
  assign illegal_op    = illegal_q;
  assign mem_error     = mem_err_q;

endmodule
